// File: rtl/avalon_gpio_bank_if.sv
// Avalon-MM slave bus bundle for the GPIO bank: register select, write strobe,
// write data and combinational read data.
interface avalon_gpio_bank_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_gpio_bank.sv
// Parametrised Avalon-MM GPIO bank: direction register, atomic set/clear/toggle,
// synchronised inputs with sticky per-bit edge capture and a maskable level irq.
module avalon_gpio_bank #(
    parameter int unsigned      WIDTH     = 30,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    avalon_gpio_bank_if.slave  bus,
    input  logic [WIDTH-1:0]   pin_in,
    output logic [WIDTH-1:0]   pin_out,
    output logic [WIDTH-1:0]   pin_oe,
    output logic               irq
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_DIR      = 3'd1,
        REG_IRQ_MASK = 3'd2,
        REG_EDGE_CAP = 3'd3,
        REG_OUTSET   = 3'd4,
        REG_OUTCLR   = 3'd5,
        REG_OUTTGL   = 3'd6,
        REG_EDGE_POL = 3'd7
    } reg_addr_e;

    reg_addr_e        addr;
    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             writedata_unused;

    logic [WIDTH-1:0] out_q,     out_d;
    logic [WIDTH-1:0] dir_q,     dir_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [WIDTH-1:0] cap_q,     cap_d;
    logic [WIDTH-1:0] pol_q,     pol_d;
    logic [WIDTH-1:0] sync1_q,   sync1_d;
    logic [WIDTH-1:0] in_sync_q, in_sync_d;
    logic [WIDTH-1:0] in_prev_q, in_prev_d;
    logic             irq_q,     irq_d;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      rdata;

    always_comb begin
        addr  = reg_addr_e'(bus.address);
        wr    = bus.chipselect & ~bus.write_n;
        wdata = bus.writedata[WIDTH-1:0];
    end

    // Upper write-data bits beyond WIDTH carry no meaning.
    assign writedata_unused = ^bus.writedata;

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        mask_d   = mask_q;
        pol_d    = pol_q;
        clr_mask = '0;

        if (wr) begin
            case (addr)
                REG_DATA:     out_d    = wdata;
                REG_DIR:      dir_d    = wdata;
                REG_IRQ_MASK: mask_d   = wdata;
                REG_EDGE_CAP: clr_mask = wdata;
                REG_OUTSET:   out_d    = out_q | wdata;
                REG_OUTCLR:   out_d    = out_q & ~wdata;
                REG_OUTTGL:   out_d    = out_q ^ wdata;
                REG_EDGE_POL: pol_d    = wdata;
            endcase
        end

        sync1_d   = pin_in;
        in_sync_d = sync1_q;
        in_prev_d = in_sync_q;

        rise     = in_sync_q & ~in_prev_q;
        fall     = ~in_sync_q & in_prev_q;
        edge_hit = (pol_q & fall) | (~pol_q & rise);

        // Edge is OR'd after the clear so a same-cycle new edge keeps the bit set.
        cap_d = (cap_q & ~clr_mask) | edge_hit;
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= OUT_RESET;
            dir_q     <= DIR_RESET;
            mask_q    <= '0;
            cap_q     <= '0;
            pol_q     <= '0;
            sync1_q   <= '0;
            in_sync_q <= '0;
            in_prev_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            pol_q     <= pol_d;
            sync1_q   <= sync1_d;
            in_sync_q <= in_sync_d;
            in_prev_q <= in_prev_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_DATA:     rdata[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & in_sync_q);
            REG_DIR:      rdata[WIDTH-1:0] = dir_q;
            REG_IRQ_MASK: rdata[WIDTH-1:0] = mask_q;
            REG_EDGE_CAP: rdata[WIDTH-1:0] = cap_q;
            REG_OUTSET,
            REG_OUTCLR,
            REG_OUTTGL:   rdata = '0;
            REG_EDGE_POL: rdata[WIDTH-1:0] = pol_q;
        endcase
    end

    assign bus.readdata = rdata;
    assign pin_out      = out_q;
    assign pin_oe       = dir_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_gpio_bank.sv
// Self-checking bench for avalon_gpio_bank: directed tables and timed sequences,
// then randomized bus/pin traffic against a behavioural reference model.
`timescale 1ns/1ps
module tb_avalon_gpio_bank;

    localparam int unsigned WIDTH = 30;
    localparam logic [31:0] WMASK = 32'h3FFF_FFFF;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] pin_out;
    logic [WIDTH-1:0] pin_oe;
    logic             irq;

    avalon_gpio_bank_if bus();

    avalon_gpio_bank #(
        .WIDTH     (WIDTH),
        .OUT_RESET (30'h0000_0000),
        .DIR_RESET (30'h3FFF_FFFF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Register file as the software sees it; inputs reach in_sync two edges
    // after being sampled, in_prev one edge after that.
    logic [31:0] m_out, m_dir, m_mask, m_cap, m_pol;
    logic        m_irq;
    logic [31:0] smp[$];

    function automatic logic [31:0] ago(int unsigned k);
        if (smp.size() >= k) return smp[smp.size() - k];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a);
        case (a)
            3'd0:    return ((m_dir & m_out) | (~m_dir & ago(2))) & WMASK;
            3'd1:    return m_dir;
            3'd2:    return m_mask;
            3'd3:    return m_cap;
            3'd7:    return m_pol;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] wd, cur, old, clr, hit;
        if (!reset_n) begin
            m_out  <= 32'h0;
            m_dir  <= WMASK;
            m_mask <= 32'h0;
            m_cap  <= 32'h0;
            m_pol  <= 32'h0;
            m_irq  <= 1'b0;
            smp.delete();
        end else begin
            wd  = bus.writedata & WMASK;
            cur = ago(2);
            old = ago(3);
            hit = 32'h0;
            clr = 32'h0;
            for (int b = 0; b < WIDTH; b++) begin
                if (m_pol[b]) hit[b] = old[b] && !cur[b];
                else          hit[b] = cur[b] && !old[b];
            end
            m_irq <= ((m_cap & m_mask) != 32'h0);
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_out  <= wd;
                    3'd1: m_dir  <= wd;
                    3'd2: m_mask <= wd;
                    3'd3: clr = wd;
                    3'd4: m_out  <= m_out | wd;
                    3'd5: m_out  <= m_out & ~wd & WMASK;
                    3'd6: m_out  <= m_out ^ wd;
                    3'd7: m_pol  <= wd;
                    default: ;
                endcase
            end
            m_cap <= (m_cap & ~clr) | hit;
            smp.push_back(32'(pin_in));
            if (smp.size() > 8) void'(smp.pop_front());
        end
    end

    // ---------------- bus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        tick();
        set_idle();
    endtask

    task automatic check_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check(name, bus.readdata, exp);
        set_idle();
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_out;
    } wr_vec_t;

    rd_vec_t reset_tbl[8];
    wr_vec_t atomic_tbl[4];
    rd_vec_t wo_tbl[3];

    initial begin
        reset_tbl[0] = '{3'd0, 32'h0000_0000};
        reset_tbl[1] = '{3'd1, 32'h3FFF_FFFF};
        reset_tbl[2] = '{3'd2, 32'h0000_0000};
        reset_tbl[3] = '{3'd3, 32'h0000_0000};
        reset_tbl[4] = '{3'd7, 32'h0000_0000};
        reset_tbl[5] = '{3'd4, 32'h0000_0000};
        reset_tbl[6] = '{3'd5, 32'h0000_0000};
        reset_tbl[7] = '{3'd6, 32'h0000_0000};

        atomic_tbl[0] = '{3'd0, 32'h0000_00F0, 32'h0000_00F0};
        atomic_tbl[1] = '{3'd4, 32'h0000_000F, 32'h0000_00FF};
        atomic_tbl[2] = '{3'd5, 32'h0000_0030, 32'h0000_00CF};
        atomic_tbl[3] = '{3'd6, 32'h0000_0101, 32'h0000_01CE};

        wo_tbl[0] = '{3'd4, 32'h0};
        wo_tbl[1] = '{3'd5, 32'h0};
        wo_tbl[2] = '{3'd6, 32'h0};

        reset_n = 1'b0;
        pin_in  = '0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Reset defaults
        for (int i = 0; i < 8; i++) begin
            check_rd($sformatf("reset_rd_addr%0d", reset_tbl[i].addr), reset_tbl[i].addr, reset_tbl[i].exp);
            tick();
        end
        check("reset_pin_oe", 32'(pin_oe), 32'h3FFF_FFFF);
        check("reset_pin_out", 32'(pin_out), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // Atomic output operations
        for (int i = 0; i < 4; i++) begin
            bus_write(atomic_tbl[i].addr, atomic_tbl[i].wdata);
            check($sformatf("atomic_pin_out_%0d", i), 32'(pin_out), atomic_tbl[i].exp_out);
        end
        for (int i = 0; i < 3; i++) begin
            check_rd($sformatf("wo_read_addr%0d", wo_tbl[i].addr), wo_tbl[i].addr, wo_tbl[i].exp);
            tick();
        end

        // Input and direction: mixed DATA read, two-edge latency
        bus_write(3'd1, 32'h0000_FFFF);
        bus_write(3'd0, 32'hFFFF_FFFF);
        check("dir_pin_oe", 32'(pin_oe), 32'h0000_FFFF);
        check("dir_pin_out", 32'(pin_out), 32'h3FFF_FFFF);
        pin_in = 30'h3FFF_0000;
        check_rd("data_before_e0", 3'd0, 32'h0000_FFFF);
        tick();
        check_rd("data_after_e0", 3'd0, 32'h0000_FFFF);
        tick();
        check_rd("data_after_e1", 3'd0, 32'h3FFF_FFFF);
        tick();
        tick();
        bus_write(3'd3, 32'hFFFF_FFFF);
        check_rd("cap_cleared_all", 3'd3, 32'h0);

        // Rising-edge interrupt and W1C
        bus_write(3'd2, 32'h1);
        bus_write(3'd7, 32'h0);
        pin_in[0] = 1'b1;
        tick();
        tick();
        check_rd("rise_cap_e1", 3'd3, 32'h0);
        tick();
        check_rd("rise_cap_e2", 3'd3, 32'h1);
        check("rise_irq_e2", 32'(irq), 32'h0);
        tick();
        check("rise_irq_e3", 32'(irq), 32'h1);
        bus_write(3'd3, 32'h1);
        check_rd("w1c_cap", 3'd3, 32'h0);
        check("w1c_irq_ec", 32'(irq), 32'h1);
        tick();
        check("w1c_irq_ec1", 32'(irq), 32'h0);
        pin_in[0] = 1'b0;
        repeat (4) tick();
        check_rd("fall_ignored_cap", 3'd3, 32'h0);
        check("fall_ignored_irq", 32'(irq), 32'h0);

        // Falling edge coinciding with W1C of the same bit
        bus_write(3'd7, 32'h8);
        pin_in[3] = 1'b1;
        repeat (4) tick();
        check_rd("pol_rise_ignored", 3'd3, 32'h0);
        pin_in[3] = 1'b0;
        tick();
        tick();
        bus_write(3'd3, 32'h8);
        check_rd("edge_beats_clear", 3'd3, 32'h8);
        bus_write(3'd3, 32'h8);
        check_rd("clear_after_race", 3'd3, 32'h0);

        // Asynchronous reset mid-operation
        bus_write(3'd7, 32'h0);
        bus_write(3'd2, 32'h5);
        pin_in = pin_in | 30'h5;
        repeat (5) tick();
        check_rd("pre_reset_cap", 3'd3, 32'h5);
        check("pre_reset_irq", 32'(irq), 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_irq", 32'(irq), 32'h0);
        check("async_pin_out", 32'(pin_out), 32'h0);
        check("async_pin_oe", 32'(pin_oe), 32'h3FFF_FFFF);
        check_rd("async_cap", 3'd3, 32'h0);
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = 1'($urandom_range(0, 1));
            bus.writedata  = $urandom;
            if ($urandom_range(0, 2) == 0)
                pin_in = pin_in ^ (WIDTH'($urandom) & WIDTH'($urandom));
            #1;
            check("rnd_readdata", bus.readdata, m_read(bus.address));
            tick();
            check("rnd_pin_out", 32'(pin_out), m_out);
            check("rnd_pin_oe", 32'(pin_oe), m_dir);
            check("rnd_irq", 32'(irq), 32'(m_irq));
        end
        set_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
